// File: rtl/bcd_count_ctrl_if.sv
// Bus bundle for the BCD event counter: count source, commands, live count
// and the multiplexed display outputs.
interface bcd_count_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  cnt_in;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  latch;
  logic [4*DIGITS-1:0]   value;
  logic                  carry;
  logic                  overflow;
  logic [3:0]            seg_d;
  logic [DIGITS-1:0]     dig_sel;

  modport master (
    output cnt_in, clear, load, load_val, latch,
    input  value, carry, overflow, seg_d, dig_sel
  );

  modport slave (
    input  cnt_in, clear, load, load_val, latch,
    output value, carry, overflow, seg_d, dig_sel
  );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Multi-digit BCD event counter with snapshot latch and a time-multiplexed
// digit scanner for an LED/decoder stage.
module bcd_count_ctrl #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  bcd_count_ctrl_if.slave bus
);

  localparam int VAL_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  // Out-of-range preset nibbles collapse to zero so the count stays valid BCD.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd0 : nib;
  endfunction

  // Returns {carry_out, next_digit} for one decade stage.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic ci);
    if (!ci)
      return {1'b0, d};
    if (d >= 4'd9)
      return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  logic               cnt_sync_p0;
  logic               cnt_sync_p1;
  logic               cnt_prev_p2;
  logic               cnt_en;

  logic [VAL_W-1:0]   value_q;
  logic [VAL_W-1:0]   value_inc;
  logic [VAL_W-1:0]   load_clean;
  logic               wrap;
  logic               carry_q;
  logic               ovf_q;

  logic [VAL_W-1:0]   disp_q;

  logic [PRE_W-1:0]   pre_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DIGITS-1:0]  zero_from;
  logic [3:0]         seg_d;
  logic [DIGITS-1:0]  dig_sel;

  // Stage p0..p2: synchronizer plus edge-detect history; reset high so a
  // held-high input does not produce a count on reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_sync_p0 <= 1'b1;
      cnt_sync_p1 <= 1'b1;
      cnt_prev_p2 <= 1'b1;
    end else begin
      cnt_sync_p0 <= bus.cnt_in;
      cnt_sync_p1 <= cnt_sync_p0;
      cnt_prev_p2 <= cnt_sync_p1;
    end
  end

  assign cnt_en = cnt_sync_p1 & ~cnt_prev_p2;

  always_comb begin
    logic       c;
    logic [4:0] r;
    c          = cnt_en;
    r          = '0;
    value_inc  = value_q;
    load_clean = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r                     = bcd_inc(value_q[4*i +: 4], c);
      value_inc[4*i +: 4]   = r[3:0];
      c                     = r[4];
      load_clean[4*i +: 4]  = bcd_sanitize(bus.load_val[4*i +: 4]);
    end
    wrap = c;
  end

  // Count register: clear beats load beats count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      value_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.load) begin
      value_q <= load_clean;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_inc;
      carry_q <= wrap;
      if (wrap)
        ovf_q <= 1'b1;
    end
  end

  // Snapshot takes the pre-update count, so a coincident command never leaks in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      disp_q <= '0;
    else if (bus.latch)
      disp_q <= value_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Display decode: purely from registers so seg_d and dig_sel move together.
  always_comb begin
    logic z;
    z         = 1'b1;
    zero_from = '0;
    seg_d     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z            = z & (disp_q[4*i +: 4] == 4'd0);
      zero_from[i] = z;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i))
        seg_d = (BLANK_LZ && (i != 0) && zero_from[i]) ? 4'hF : disp_q[4*i +: 4];
    end
    dig_sel = DIGITS'(1) << idx_q;
  end

  assign bus.value    = value_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.seg_d    = seg_d;
  assign bus.dig_sel  = dig_sel;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl: count latency, ripple, wrap, command
// priority, snapshot latch, display scan and asynchronous reset.
module tb_bcd_count_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic clk = 1'b0;
  logic reset;

  bcd_count_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_count_ctrl #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          carry_cnt = 0;
  int          ncyc      = 0;
  logic [15:0] sb[$];
  logic [15:0] last_val;

  always @(negedge clk)
    if (bus.carry === 1'b1)
      carry_cnt <= carry_cnt + 1;

  // Clock edges since reset release; drives the expected scan position.
  always @(posedge clk or posedge reset)
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic c, input logic l, input logic [15:0] lv, input logic lt);
    @(negedge clk);
    bus.clear = c; bus.load = l; bus.load_val = lv; bus.latch = lt;
    @(negedge clk);
    bus.clear = 1'b0; bus.load = 1'b0; bus.latch = 1'b0;
  endtask

  task automatic cmd_chk(input string tag, input logic c, input logic l,
                         input logic [15:0] lv, input logic [15:0] exp);
    cmd(c, l, lv, 1'b0);
    chk(tag, bus.value, exp);
    last_val = exp;
  endtask

  task automatic pulse(input logic [15:0] exp, input logic exp_carry);
    logic [15:0] e;
    sb.push_back(exp);
    @(negedge clk);
    bus.cnt_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("cnt_early", bus.value, last_val);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cnt_value", bus.value, e);
    chk("cnt_carry", bus.carry, exp_carry);
    last_val = e;
    @(negedge clk);
    bus.cnt_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Count edge arrives with a command held on the edge where the enable is live.
  task automatic cnt_with_cmd(input logic l, input logic [15:0] lv, input logic lt,
                              input logic [15:0] exp, input string tag);
    logic [15:0] e;
    sb.push_back(exp);
    @(negedge clk);
    bus.cnt_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.load = l; bus.load_val = lv; bus.latch = lt;
    @(negedge clk);
    bus.load = 1'b0; bus.latch = 1'b0;
    e = sb.pop_front();
    chk(tag, bus.value, e);
    last_val = e;
    repeat (4) @(negedge clk);
    chk({tag, "_hold"}, bus.value, e);
    bus.cnt_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3);
    logic [3:0] exp_seg[4];
    int k;
    exp_seg = '{s0, s1, s2, s3};
    for (int w = 0; w < FRAME && (ncyc % FRAME) != 0; w++) @(negedge clk);
    for (int n = 0; n < FRAME; n++) begin
      k = (ncyc / SCAN_DIV) % DIGITS;
      chk("scan_sel", bus.dig_sel, 32'(1) << k);
      chk("scan_seg", bus.seg_d, exp_seg[k]);
      @(negedge clk);
    end
  endtask

  initial begin
    int c0;
    bus.cnt_in = 1'b1; bus.clear = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.latch = 1'b0;
    reset = 1'b1;
    last_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_value", bus.value, 16'h0000);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_sel", bus.dig_sel, 4'b0001);
    chk("rst_seg", bus.seg_d, 4'h0);
    reset = 1'b0;

    c0 = carry_cnt;
    repeat (10) @(negedge clk);
    chk("idle_value", bus.value, 16'h0000);
    chk("idle_ovf", bus.overflow, 1'b0);
    chk("idle_carry", carry_cnt - c0, 0);
    bus.cnt_in = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 1; i <= 12; i++) pulse(to_bcd(i), 1'b0);
    chk("count12", bus.value, 16'h0012);

    cmd_chk("load0099", 1'b0, 1'b1, 16'h0099, 16'h0099);
    pulse(16'h0100, 1'b0);

    cmd_chk("load9998", 1'b0, 1'b1, 16'h9998, 16'h9998);
    pulse(16'h9999, 1'b0);
    c0 = carry_cnt;
    pulse(16'h0000, 1'b1);
    chk("wrap_ovf", bus.overflow, 1'b1);
    chk("wrap_carry_cycles", carry_cnt - c0, 1);
    pulse(16'h0001, 1'b0);
    chk("ovf_sticky", bus.overflow, 1'b1);
    cmd_chk("clear", 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("clear_ovf", bus.overflow, 1'b0);

    cmd_chk("clr_over_load", 1'b1, 1'b1, 16'h1234, 16'h0000);
    cmd_chk("bad_nibble", 1'b0, 1'b1, 16'h12A4, 16'h1204);
    cnt_with_cmd(1'b1, 16'h0555, 1'b0, 16'h0555, "load_vs_cnt");

    cmd_chk("load0041", 1'b0, 1'b1, 16'h0041, 16'h0041);
    pulse(16'h0042, 1'b0);
    cnt_with_cmd(1'b0, 16'h0000, 1'b1, 16'h0043, "latch_cnt");
    frame(4'h2, 4'h4, 4'hF, 4'hF);
    cmd_chk("load0000", 1'b0, 1'b1, 16'h0000, 16'h0000);
    cmd(1'b0, 1'b0, 16'h0000, 1'b1);
    frame(4'h0, 4'hF, 4'hF, 4'hF);

    cmd_chk("load0777", 1'b0, 1'b1, 16'h0777, 16'h0777);
    for (int w = 0; w < FRAME && (ncyc % FRAME) != 5; w++) @(negedge clk);
    bus.cnt_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_value", bus.value, 16'h0000);
    chk("mid_rst_ovf", bus.overflow, 1'b0);
    chk("mid_rst_carry", bus.carry, 1'b0);
    chk("mid_rst_sel", bus.dig_sel, 4'b0001);
    chk("mid_rst_seg", bus.seg_d, 4'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_nocount", bus.value, 16'h0000);
    bus.cnt_in = 1'b0;
    repeat (3) @(negedge clk);
    last_val = 16'h0000;
    pulse(16'h0001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
